// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the two memory masters, the arbiter and the unified single-port memory.
// The arbiter side uses the slave modport; the masters/memory side uses master.
interface mem_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          m0_req;
  logic          m0_we;
  logic [AW-1:0] m0_addr;
  logic [DW-1:0] m0_wdata;
  logic          m0_ready;
  logic          m0_rvalid;
  logic [DW-1:0] m0_rdata;

  logic          m1_req;
  logic          m1_we;
  logic [AW-1:0] m1_addr;
  logic [DW-1:0] m1_wdata;
  logic          m1_ready;
  logic          m1_rvalid;
  logic [DW-1:0] m1_rdata;

  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_data_out;
  logic [DW-1:0] mem_data_in;
  logic          mem_we;
  logic          busy;

  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata,
    input  m1_req, m1_we, m1_addr, m1_wdata,
    input  mem_data_in,
    output m0_ready, m0_rvalid, m0_rdata,
    output m1_ready, m1_rvalid, m1_rdata,
    output mem_address, mem_data_out, mem_we, busy
  );

  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata,
    output m1_req, m1_we, m1_addr, m1_wdata,
    output mem_data_in,
    input  m0_ready, m0_rvalid, m0_rdata,
    input  m1_ready, m1_rvalid, m1_rdata,
    input  mem_address, mem_data_out, mem_we, busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-master round-robin arbiter in front of the single-port unified memory.
// Optional grant counters (m0_grants/m1_grants) are built when ARB_STATS_EN is defined.
module mem_port_arbiter #(
  parameter int AW     = 32,
  parameter int DW     = 32,
  parameter int RD_LAT = 1
) (
  input  logic                clk,
  input  logic                reset,
  mem_port_arbiter_if.slave   bus
`ifdef ARB_STATS_EN
  ,
  output logic [15:0]         m0_grants,
  output logic [15:0]         m1_grants
`endif
);

  typedef enum logic [1:0] {IDLE, ISSUE, RDWAIT, RESP} state_t;

  localparam logic [2:0] LAT_M1 = (RD_LAT == 0) ? 3'd0 : 3'(RD_LAT - 1);

  state_t        state, state_nxt;
  logic          ptr;      // 1: m1 wins a tie, 0: m0 wins a tie
  logic          owner;
  logic          rd_q;
  logic [2:0]    cnt;
  logic          we_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] rdata0_q, rdata1_q;
  logic          grant0, grant1;
  logic          ready0, ready1;
  logic          capture;

  assign grant0 = bus.m0_req && (!bus.m1_req || !ptr);
  assign grant1 = bus.m1_req && (!bus.m0_req ||  ptr);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Ready is gated by reset so a held request is never acknowledged while reset is asserted.
  always_comb begin
    state_nxt = state;
    ready0    = 1'b0;
    ready1    = 1'b0;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        if (!reset) begin
          ready0 = grant0;
          ready1 = grant1;
          if (grant0 || grant1) state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        if (!rd_q) begin
          state_nxt = IDLE;
        end else if (RD_LAT == 0) begin
          capture   = 1'b1;
          state_nxt = RESP;
        end else begin
          state_nxt = RDWAIT;
        end
      end
      RDWAIT: begin
        if (cnt == 3'd0) begin
          capture   = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Grant edge: latch the winner's fields straight into the memory bus registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr      <= 1'b0;
      owner    <= 1'b0;
      rd_q     <= 1'b0;
      cnt      <= 3'd0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      if (ready0 || ready1) begin
        owner   <= ready1;
        ptr     <= ready0;
        rd_q    <= ready1 ? !bus.m1_we : !bus.m0_we;
        we_q    <= ready1 ?  bus.m1_we :  bus.m0_we;
        addr_q  <= ready1 ? bus.m1_addr  : bus.m0_addr;
        wdata_q <= ready1 ? bus.m1_wdata : bus.m0_wdata;
      end else begin
        we_q    <= 1'b0;
      end
      if (state == ISSUE)                       cnt <= LAT_M1;
      else if (state == RDWAIT && cnt != 3'd0)  cnt <= cnt - 3'd1;
      if (capture && !owner) rdata0_q <= bus.mem_data_in;
      if (capture &&  owner) rdata1_q <= bus.mem_data_in;
    end
  end

  assign bus.m0_ready     = ready0;
  assign bus.m1_ready     = ready1;
  assign bus.m0_rvalid    = (state == RESP) && !owner;
  assign bus.m1_rvalid    = (state == RESP) &&  owner;
  assign bus.m0_rdata     = rdata0_q;
  assign bus.m1_rdata     = rdata1_q;
  assign bus.mem_address  = addr_q;
  assign bus.mem_data_out = wdata_q;
  assign bus.mem_we       = we_q;
  assign bus.busy         = (state != IDLE);

`ifdef ARB_STATS_EN
  logic [15:0] g0_q, g1_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      g0_q <= 16'd0;
      g1_q <= 16'd0;
    end else begin
      if (ready0 && g0_q != 16'hFFFF) g0_q <= g0_q + 16'd1;
      if (ready1 && g1_q != 16'hFFFF) g1_q <= g1_q + 16'd1;
    end
  end

  assign m0_grants = g0_q;
  assign m1_grants = g1_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomised scoreboard bench for mem_port_arbiter: a transaction-level model predicts grants,
// bus activity and read responses; a negedge monitor compares them against the DUT.
module tb_mem_port_arbiter;
  localparam int AW     = 32;
  localparam int DW     = 32;
  localparam int RD_LAT = 3;

  typedef struct {
    longint        cyc;
    logic [DW-1:0] data;
  } resp_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  logic          req   [2] = '{1'b0, 1'b0};
  logic          we    [2] = '{1'b0, 1'b0};
  logic [AW-1:0] addr  [2] = '{'0, '0};
  logic [DW-1:0] wdata [2] = '{'0, '0};
  logic [DW-1:0] mem_in = '0;

  int     checks = 0;
  int     errors = 0;
  longint cyc    = 0;
  int     acc_cnt [2] = '{0, 0};
  int     seen    [2] = '{0, 0};

  // bench-side memory and reference model state
  logic [DW-1:0] mem_store [logic [AW-1:0]];
  logic [DW-1:0] model_mem [logic [AW-1:0]];
  longint        dut_gcyc = -100;
  longint        free     = 0;
  bit            last     = 1'b1;
  resp_t         rq0[$], rq1[$];
  bit            iss_valid = 1'b0;
  longint        iss_cyc;
  bit            iss_we;
  logic [AW-1:0] iss_addr;
  logic [DW-1:0] iss_data;
  bit            r0, r1, w, gnt, exp_r0, exp_r1, exp_we, exp_v;
  logic [DW-1:0] rd_exp;

  mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  assign bus.m0_req      = req[0];
  assign bus.m0_we       = we[0];
  assign bus.m0_addr     = addr[0];
  assign bus.m0_wdata    = wdata[0];
  assign bus.m1_req      = req[1];
  assign bus.m1_we       = we[1];
  assign bus.m1_addr     = addr[1];
  assign bus.m1_wdata    = wdata[1];
  assign bus.mem_data_in = mem_in;

`ifdef ARB_STATS_EN
  logic [15:0] m0_grants, m1_grants;
  logic [15:0] gcnt0 = 16'd0, gcnt1 = 16'd0;
  bit          sat_set = 1'b0;
`endif

  mem_port_arbiter #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef ARB_STATS_EN
    ,
    .m0_grants (m0_grants),
    .m1_grants (m1_grants)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] dflt(input logic [AW-1:0] a);
    return DW'(a * 32'h9E3779B1);
  endfunction

  function automatic logic [DW-1:0] store_rd(input logic [AW-1:0] a);
    return mem_store.exists(a) ? mem_store[a] : dflt(a);
  endfunction

  function automatic logic [DW-1:0] model_rd(input logic [AW-1:0] a);
    return model_mem.exists(a) ? model_mem[a] : dflt(a);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  // Memory emulation plus scoreboard, all sampled at the falling edge.
  always @(negedge clk) begin
    if (bus.mem_we) mem_store[bus.mem_address] = bus.mem_data_out;
    if (!reset && cyc == dut_gcyc + 1 + RD_LAT) mem_in = store_rd(bus.mem_address);
    else                                         mem_in = DW'(32'hBAD0_0000) ^ DW'(cyc);
    if (bus.m0_ready || bus.m1_ready) dut_gcyc = cyc;
    if (bus.m0_ready) acc_cnt[0]++;
    if (bus.m1_ready) acc_cnt[1]++;

    if (reset) begin
      chk("reset_ctrl", {58'd0, bus.m0_ready, bus.m1_ready, bus.m0_rvalid, bus.m1_rvalid,
                         bus.mem_we, bus.busy}, 64'd0);
      chk("reset_data", 64'(bus.mem_address | bus.mem_data_out | bus.m0_rdata | bus.m1_rdata), 64'd0);
      free = 0; last = 1'b1; iss_valid = 1'b0;
      rq0.delete(); rq1.delete();
`ifdef ARB_STATS_EN
      gcnt0 = 16'd0; gcnt1 = 16'd0;
      chk("reset_grants", {32'd0, m0_grants, m1_grants}, 64'd0);
`endif
    end else begin
      r0 = req[0]; r1 = req[1];
      gnt = (cyc >= free) && (r0 || r1);
      w = (r0 && r1) ? !last : r1;
      exp_r0 = gnt && !w;
      exp_r1 = gnt && w;
      chk("m0_ready", 64'(bus.m0_ready), 64'(exp_r0));
      chk("m1_ready", 64'(bus.m1_ready), 64'(exp_r1));
      chk("busy", 64'(bus.busy), 64'(cyc < free));
      exp_we = iss_valid && iss_cyc == cyc && iss_we;
      chk("mem_we", 64'(bus.mem_we), 64'(exp_we));
      if (iss_valid && iss_cyc == cyc) begin
        chk("mem_address", 64'(bus.mem_address), 64'(iss_addr));
        if (iss_we) chk("mem_data_out", 64'(bus.mem_data_out), 64'(iss_data));
        iss_valid = 1'b0;
      end
      exp_v = rq0.size() > 0 && rq0[0].cyc <= cyc;
      chk("m0_rvalid", 64'(bus.m0_rvalid), 64'(exp_v));
      if (exp_v) begin
        chk("m0_rdata", 64'(bus.m0_rdata), 64'(rq0[0].data));
        void'(rq0.pop_front());
      end
      exp_v = rq1.size() > 0 && rq1[0].cyc <= cyc;
      chk("m1_rvalid", 64'(bus.m1_rvalid), 64'(exp_v));
      if (exp_v) begin
        chk("m1_rdata", 64'(bus.m1_rdata), 64'(rq1[0].data));
        void'(rq1.pop_front());
      end
`ifdef ARB_STATS_EN
      if (sat_set) gcnt0 = 16'hFFFF;
      chk("m0_grants", 64'(m0_grants), 64'(gcnt0));
      chk("m1_grants", 64'(m1_grants), 64'(gcnt1));
      if (exp_r0 && gcnt0 != 16'hFFFF) gcnt0++;
      if (exp_r1 && gcnt1 != 16'hFFFF) gcnt1++;
`endif
      if (gnt) begin
        last      = w;
        iss_valid = 1'b1;
        iss_cyc   = cyc + 1;
        iss_we    = we[w];
        iss_addr  = addr[w];
        iss_data  = wdata[w];
        if (we[w]) begin
          model_mem[addr[w]] = wdata[w];
          free = cyc + 2;
        end else begin
          rd_exp = model_rd(addr[w]);
          if (w) rq1.push_back('{cyc + 2 + RD_LAT, rd_exp});
          else   rq0.push_back('{cyc + 2 + RD_LAT, rd_exp});
          free = cyc + 3 + RD_LAT;
        end
      end
    end
  end

  // All driver tasks start and end just after a rising edge.
  task automatic do_txn(input int k, input bit t_we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bit ok = 1'b0;
    we[k] = t_we; addr[k] = a; wdata[k] = d; req[k] = 1'b1;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(posedge clk); #1;
      if (acc_cnt[k] != seen[k]) begin
        seen[k] = acc_cnt[k];
        ok = 1'b1;
      end
    end
    req[k] = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL txn_timeout m%0d got=no_ready expected=ready", k);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
    seen = acc_cnt;
    idle(1);
  endtask

  // p: request probability in eighths; wmode: 0 read, 1 write, 2 random
  task automatic run_random(input int n, input int p, input int wmode);
    for (int i = 0; i < n; i++) begin
      for (int k = 0; k < 2; k++) begin
        if (acc_cnt[k] != seen[k]) begin
          seen[k] = acc_cnt[k];
          req[k]  = 1'b0;
        end
        if (!req[k] && int'($urandom_range(0, 7)) < p) begin
          we[k]    = (wmode == 2) ? 1'($urandom_range(0, 1)) : 1'(wmode);
          addr[k]  = 32'h100 + 32'($urandom_range(0, 7) << 2);
          wdata[k] = $urandom;
          req[k]   = 1'b1;
        end else if (req[k] && p < 8 && $urandom_range(0, 15) == 0) begin
          req[k] = 1'b0;
        end
      end
      @(posedge clk); #1;
    end
    req[0] = 1'b0;
    req[1] = 1'b0;
    seen = acc_cnt;
  endtask

  initial begin
    mem_store[32'h10] = 32'h12345678;
    model_mem[32'h10] = 32'h12345678;
    req[0] = 1'b1; req[1] = 1'b1;
    idle(3);
    req[0] = 1'b0; req[1] = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    seen = acc_cnt;
    idle(2);

    do_txn(0, 1'b1, 32'h804, 32'hDEADBEEF);
    idle(3);
    do_txn(0, 1'b0, 32'h10, '0);
    idle(RD_LAT + 4);

    pulse_reset();
    run_random(10, 8, 1);
    idle(4);

    pulse_reset();
    do_txn(0, 1'b0, 32'h10, '0);
    idle(1);
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
    seen = acc_cnt;
    idle(RD_LAT + 4);
    do_txn(1, 1'b0, 32'h10, '0);
    idle(RD_LAT + 4);

    run_random(600, 3, 2);
    idle(RD_LAT + 6);
    chk("m0_pending_resp", 64'(rq0.size()), 64'd0);
    chk("m1_pending_resp", 64'(rq1.size()), 64'd0);

`ifdef ARB_STATS_EN
    pulse_reset();
    for (int i = 0; i < 3; i++) begin
      do_txn(0, 1'b1, 32'h200, 32'(i));
      idle(2);
    end
    for (int i = 0; i < 2; i++) begin
      do_txn(1, 1'b1, 32'h204, 32'(i));
      idle(2);
    end
    chk("grants_3_2", {32'd0, m0_grants, m1_grants}, {32'd0, 16'd3, 16'd2});
    force dut.g0_q = 16'hFFFF;
    sat_set = 1'b1;
    @(posedge clk); #1;
    release dut.g0_q;
    sat_set = 1'b0;
    do_txn(0, 1'b1, 32'h208, 32'h1);
    idle(3);
    chk("grants_saturate", 64'(m0_grants), 64'hFFFF);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
